// File: rtl/comparator_pkg.sv
// Shared definitions for the sequential magnitude comparator:
// FSM state encoding, result flag encoding and the offset-binary helper.
package comparator_pkg;

  // Widest operand the offset helper can handle.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result flags packed as {b_gt, b_a_eq, a_gt}.
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_B_GT = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_A_GT = 3'b001;

  // Flip the operand MSB so two's-complement values order correctly as unsigned.
  function automatic logic [MAX_W-1:0] to_offset(input logic [MAX_W-1:0] v,
                                                 input logic signed_en,
                                                 input int width);
    logic [MAX_W-1:0] r;
    r = v;
    if (signed_en) begin
      r[width-1] = ~v[width-1];
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/comparator_digit.sv
// Combinational compare of one DIGIT-wide slice of each operand.
module comparator_digit
  import comparator_pkg::*;
#(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] bs,
  input  logic [DIGIT-1:0] as,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  assign gt = (bs > as);
  assign eq = (bs == as);
  assign lt = (bs < as);

endmodule

// File: rtl/comparator_seq.sv
// Multi-cycle magnitude comparator (b vs a), DIGIT bits per cycle, MSB slice first.
// Optional build macro COMPARATOR_SEQ_EARLY_EXIT_EN: finish on the first differing
// slice instead of always walking all NDIG slices.
module comparator_seq
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_en,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic             b_gt,
  output logic             b_a_eq,
  output logic             a_gt
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG) + 1;

`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  if (WIDTH < 2) begin : g_chk_width
    $error("comparator_seq: WIDTH must be >= 2");
  end
  if ((WIDTH % DIGIT) != 0) begin : g_chk_digit
    $error("comparator_seq: WIDTH must be a multiple of DIGIT");
  end
  if (WIDTH > MAX_W) begin : g_chk_max
    $error("comparator_seq: WIDTH exceeds MAX_W");
  end

  state_t           state_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] a_r;
  logic [CW-1:0]    cnt_r;
  logic             decided_r;
  logic [2:0]       dec_res_r;
  logic [2:0]       flags_r;
  logic             busy_r;
  logic             done_r;

  logic [WIDTH-1:0] b_off_s;
  logic [WIDTH-1:0] a_off_s;
  logic [WIDTH-1:0] b_sh_s;
  logic [WIDTH-1:0] a_sh_s;
  logic [DIGIT-1:0] bs_s;
  logic [DIGIT-1:0] as_s;
  logic             gt_s;
  logic             eq_s;
  logic             lt_s;
  logic             last_s;
  logic             exit_s;
  logic [2:0]       next_res_s;

  // Offset-binary form of the incoming operands, stored at the capture edge.
  assign b_off_s = WIDTH'(to_offset(MAX_W'(b), signed_en, WIDTH));
  assign a_off_s = WIDTH'(to_offset(MAX_W'(a), signed_en, WIDTH));

  // Slice mux: shift the current slice up to the MSB end, then take the top DIGIT bits.
  assign b_sh_s = b_r << (int'(cnt_r) * DIGIT);
  assign a_sh_s = a_r << (int'(cnt_r) * DIGIT);
  assign bs_s   = b_sh_s[WIDTH-1 -: DIGIT];
  assign as_s   = a_sh_s[WIDTH-1 -: DIGIT];

  comparator_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .bs (bs_s),
    .as (as_s),
    .gt (gt_s),
    .eq (eq_s),
    .lt (lt_s)
  );

  // Result this slice would produce, giving priority to an earlier decision.
  always_comb begin
    next_res_s = RES_NONE;
    last_s     = (cnt_r == CW'(NDIG - 1));
    if (decided_r) begin
      next_res_s = dec_res_r;
    end else if (gt_s) begin
      next_res_s = RES_B_GT;
    end else if (lt_s) begin
      next_res_s = RES_A_GT;
    end else begin
      next_res_s = RES_EQ;
    end
    if (EARLY) begin
      exit_s = last_s || (!decided_r && !eq_s);
    end else begin
      exit_s = last_s;
    end
  end

  // FSM, operand capture, slice counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      b_r       <= '0;
      a_r       <= '0;
      cnt_r     <= '0;
      decided_r <= 1'b0;
      dec_res_r <= RES_NONE;
      flags_r   <= RES_NONE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (start) begin
            b_r       <= b_off_s;
            a_r       <= a_off_s;
            cnt_r     <= '0;
            decided_r <= 1'b0;
            dec_res_r <= RES_NONE;
            busy_r    <= 1'b1;
            state_r   <= CMP;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        CMP: begin
          cnt_r <= cnt_r + CW'(1);
          if (!decided_r && !eq_s) begin
            decided_r <= 1'b1;
            dec_res_r <= next_res_s;
          end else begin
            decided_r <= decided_r;
          end
          if (exit_s) begin
            flags_r <= next_res_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign b_gt   = flags_r[2];
  assign b_a_eq = flags_r[1];
  assign a_gt   = flags_r[0];

endmodule

// File: tb/tb_comparator_seq.sv
// Scoreboard bench for comparator_seq: three instances (8/2, 4/1, 4/4) share clk/rst_n.
module tb_comparator_seq;

  typedef struct {
    logic [2:0] flags;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start [3];
  logic       sgn   [3];
  logic [7:0] bop   [3];
  logic [7:0] aop   [3];
  logic       busy  [3];
  logic       done  [3];
  logic       bgt   [3];
  logic       beq   [3];
  logic       agt   [3];

  exp_t q [3][$];
  int   bcnt [3];
  int   n_tests = 0;
  int   n_fail  = 0;

`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  always #5 clk = ~clk;

  comparator_seq #(.WIDTH(8), .DIGIT(2)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .signed_en(sgn[0]),
    .b(bop[0]), .a(aop[0]), .busy(busy[0]), .done(done[0]),
    .b_gt(bgt[0]), .b_a_eq(beq[0]), .a_gt(agt[0]));

  comparator_seq #(.WIDTH(4), .DIGIT(1)) u41 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .signed_en(sgn[1]),
    .b(bop[1][3:0]), .a(aop[1][3:0]), .busy(busy[1]), .done(done[1]),
    .b_gt(bgt[1]), .b_a_eq(beq[1]), .a_gt(agt[1]));

  comparator_seq #(.WIDTH(4), .DIGIT(4)) u44 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .signed_en(sgn[2]),
    .b(bop[2][3:0]), .a(aop[2][3:0]), .busy(busy[2]), .done(done[2]),
    .b_gt(bgt[2]), .b_a_eq(beq[2]), .a_gt(agt[2]));

  // Reference: relational compare on integer values, latency from the highest differing bit.
  function automatic exp_t model(input int id, input bit s, input int bv, input int av);
    exp_t e;
    int w;
    int d;
    int x;
    int y;
    int p;
    w = (id == 0) ? 8 : 4;
    d = (id == 0) ? 2 : ((id == 1) ? 1 : 4);
    x = bv & ((1 << w) - 1);
    y = av & ((1 << w) - 1);
    p = -1;
    for (int i = 0; i < w; i++) begin
      if (((x ^ y) >> i) & 1) p = i;
    end
    if (s) begin
      if (x >= (1 << (w - 1))) x = x - (1 << w);
      if (y >= (1 << (w - 1))) y = y - (1 << w);
    end
    if (x > y)       e.flags = 3'b100;
    else if (x == y) e.flags = 3'b010;
    else             e.flags = 3'b001;
    if (EARLY && p >= 0) e.lat = (w - 1 - p) / d + 1;
    else                 e.lat = w / d;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Drive one request for a single cycle and push its expected response.
  task automatic issue(input int id, input bit s, input logic [7:0] bv, input logic [7:0] av);
    @(negedge clk);
    start[id] = 1'b1;
    sgn[id]   = s;
    bop[id]   = bv;
    aop[id]   = av;
    q[id].push_back(model(id, s, int'(bv), int'(av)));
    @(negedge clk);
    start[id] = 1'b0;
  endtask

  task automatic wait_done(input int id);
    for (int k = 0; k < 60; k++) begin
      if (q[id].size() == 0) break;
      @(negedge clk);
    end
    check($sformatf("timeout_inst%0d", id), q[id].size(), 0);
  endtask

  task automatic wait_done_pulse(input int id);
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done[id]) break;
    end
    check("done_pulse_seen", int'(done[id]), 1);
  endtask

  // Monitor: pops expected results on every done pulse and checks flags and busy count.
  initial begin
    exp_t e;
    for (int i = 0; i < 3; i++) bcnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          bcnt[i] = 0;
        end else begin
          if (busy[i]) bcnt[i]++;
          if (done[i]) begin
            n_tests++;
            if (q[i].size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_done inst%0d: got done=1 expected no done", i);
            end else begin
              e = q[i].pop_front();
              if ({bgt[i], beq[i], agt[i]} !== e.flags || bcnt[i] != e.lat) begin
                n_fail++;
                $display("FAIL result inst%0d: got flags=%b busy=%0d expected flags=%b busy=%0d",
                         i, {bgt[i], beq[i], agt[i]}, bcnt[i], e.flags, e.lat);
              end
            end
            bcnt[i] = 0;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; sgn[i] = 1'b0; bop[i] = 8'h00; aop[i] = 8'h00;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_outputs", int'({busy[i], done[i], bgt[i], beq[i], agt[i]}), 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset mid-compare: all outputs clear at once and no done follows.
    issue(0, 1'b0, 8'hA5, 8'h5A);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", int'({busy[0], done[0], bgt[0], beq[0], agt[0]}), 0);
    q[0].delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midreset_no_done", int'({done[0], bgt[0], beq[0], agt[0]}), 0);

    // Directed cases.
    issue(0, 1'b0, 8'hA5, 8'h5A); wait_done(0);
    issue(0, 1'b1, 8'h80, 8'h01); wait_done(0);
    issue(0, 1'b0, 8'h80, 8'h01); wait_done(0);
    issue(0, 1'b0, 8'h3C, 8'h3C); wait_done(0);
    issue(0, 1'b1, 8'h80, 8'h7F); wait_done(0);
    issue(0, 1'b1, 8'hFF, 8'hFF); wait_done(0);
    issue(0, 1'b1, 8'hFF, 8'h00); wait_done(0);

    // Start held into the busy period with new operands: must be ignored.
    @(negedge clk);
    start[0] = 1'b1; sgn[0] = 1'b0; bop[0] = 8'hA5; aop[0] = 8'h5A;
    q[0].push_back(model(0, 1'b0, 32'hA5, 32'h5A));
    @(negedge clk);
    bop[0] = 8'h00; aop[0] = 8'hFF;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0);
    repeat (8) @(negedge clk);
    check("ignored_start_queue", q[0].size(), 0);

    // Back-to-back: start during done, busy again in the very next cycle.
    issue(0, 1'b0, 8'h12, 8'h13);
    wait_done_pulse(0);
    start[0] = 1'b1; sgn[0] = 1'b1; bop[0] = 8'hC0; aop[0] = 8'h40;
    q[0].push_back(model(0, 1'b1, 32'hC0, 32'h40));
    @(negedge clk);
    start[0] = 1'b0;
    check("back_to_back_busy", int'(busy[0]), 1);
    wait_done(0);

    // Random operands on the default geometry.
    for (int n = 0; n < 200; n++) begin
      issue(0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      wait_done(0);
    end

    // Exhaustive 4-bit sweeps with one and four bits per cycle.
    for (int id = 1; id < 3; id++) begin
      for (int s = 0; s < 2; s++) begin
        for (int bv = 0; bv < 16; bv++) begin
          for (int av = 0; av < 16; av++) begin
            issue(id, 1'(s), 8'(bv), 8'(av));
            wait_done(id);
          end
        end
      end
    end

    repeat (4) @(negedge clk);
    check("queues_drained", q[0].size() + q[1].size() + q[2].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
